burst_stream_master: RTL
========================

Name: burst_stream_master

Overview:
- Parametrised next-generation bus master for the board's AXI-lite-style slave link.
- Issues one address handshake, then a burst of BURST_LEN data beats, either reading into a local capture buffer or writing a generated pattern.
- Adds a full valid/ready handshake on every channel, burst length and last-beat signalling, write-response checking, a done pulse and an error flag.
- Displays the captured buffer on LED_OUT.

Parameters:
- DATA_W, 4, data beat width.
- ADDR_W, 3, address width.
- BURST_LEN, 8, beats per burst (2..256); buffer depth equals BURST_LEN.
- BASE_ADDR, 0, start address driven on ar_addr and aw_addr.
- DIV_COUNT, 10000000, display divider period in clk cycles (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (rst_n=1 resets).
- read_en  in  1  start read burst (sampled in IDLE).
- write_en  in  1  start write burst (sampled in IDLE).
- mode  in  2  write pattern select.
- ar_valid/ar_ready  out/in  1  read-address handshake.
- ar_addr  out  ADDR_W  read start address.
- ar_len  out  8  BURST_LEN-1.
- r_valid/r_ready  in/out  1  read-data handshake.
- r_data  in  DATA_W  read data.
- r_last  in  1  final read beat.
- aw_valid/aw_ready  out/in  1  write-address handshake.
- aw_addr  out  ADDR_W  write start address.
- aw_len  out  8  BURST_LEN-1.
- w_valid/w_ready  out/in  1  write-data handshake.
- w_data  out  DATA_W  write data.
- w_last  out  1  final write beat.
- b_valid/b_ready  in/out  1  write-response handshake.
- b_resp  in  2  response; 0 means OKAY.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse at burst completion.
- error  out  1  sticky error flag.
- LED_OUT  out  DATA_W  display output.

Behaviour:
- Reset (synchronous): state IDLE; all valid/ready outputs 0; addresses and lengths 0; w_data 0; w_last 0; busy, done and error 0; LED_OUT 0; beat counter, buffer and display index 0.
- Transfer rule: a beat completes on any cycle where valid and ready are both 1. A master valid, once raised, holds with stable payload until its handshake completes.
- Master ready/valid outputs are registered. They assert in the cycle the state is entered, via the transition edge, and drop the cycle after the final handshake.
- IDLE:
  - read_en -> RD_ADDR.
  - else write_en -> WR_ADDR.
  - Read has priority when both are high.
  - Starting a new burst clears error.
- RD_ADDR: ar_valid=1, ar_addr=BASE_ADDR, ar_len=BURST_LEN-1. On handshake -> RD_DATA with counter 0.
- RD_DATA: r_ready=1. Each accepted beat:
  - writes r_data into buf[counter] and increments counter.
  - r_last high on a beat other than BURST_LEN-1 sets error.
  - r_last low on beat BURST_LEN-1 sets error.
  - On beat BURST_LEN-1 -> IDLE with done=1.
- WR_ADDR: aw_valid=1, aw_addr=BASE_ADDR, aw_len=BURST_LEN-1. On handshake -> WR_DATA with counter 0.
- WR_DATA: w_valid=1; w_last=1 only while counter==BURST_LEN-1. Beat k data, truncated to DATA_W:
  - mode 0: 2k.
  - mode 1: 2k+1.
  - mode 2: all-ones XOR 2k.
  - mode 3: buf[k] (echo last read capture).
  - Counter advances only on handshake.
  - After beat BURST_LEN-1 -> WR_RESP.
- WR_RESP: b_ready=1. On handshake -> IDLE with done=1; b_resp!=0 sets error.
- Stalls: ready or valid low indefinitely simply holds state. There is no timeout.
- read_en/write_en outside IDLE are ignored.
- Reset mid-burst aborts immediately to the reset values above. No response is awaited.
- Counter width is ceil(log2(BURST_LEN)) and never wraps within a burst.

Optional Feature:
- Macro: LED_SCAN_EN.
- Defined:
  - A DIV_COUNT divider produces a one-cycle tick at count 0.
  - Each tick outside RD_DATA: LED_OUT<=buf[idx] and idx increments, wrapping from BURST_LEN-1 to 0.
  - In RD_DATA: LED_OUT=0 and idx holds.
- Undefined:
  - No divider logic.
  - LED_OUT shows buf[BURST_LEN-1], updated the cycle after each completed read burst.

Test Plan (BURST_LEN=8, DATA_W=4, DIV_COUNT=4 for the bench):
1. Reset held 2 cycles mid-WR_DATA -> next cycle all valids 0, busy=0, error=0, LED_OUT=0.
2. write_en, mode=1, aw_ready/w_ready always 1, b_resp=0 -> w_data sequence 1,3,5,7,9,B,D,F; w_last only on beat 8; done pulse once; error=0.
3. Same write with w_ready toggling 1/0 -> identical 8-beat sequence; w_valid and w_data stable during every stall; done after b handshake.
4. read_en and write_en together; slave returns 9,8,7,6,5,4,3,2 with r_last on beat 8 -> read taken; buffer matches; done=1; error=0. With LED_SCAN_EN, LED_OUT cycles 9..2 every 4 clocks, then wraps to 9.
5. Read burst with r_last asserted on beat 5 -> error=1 stays set; burst still completes after 8 beats. Next write with mode=3 clears error and echoes the captured buffer.
6. Write burst with b_resp=2 -> done=1, error=1. A following read_en clears error.

Source files
------------

// File: rtl/burst_stream_master.sv
// Burst bus master: one address handshake, then BURST_LEN read-capture or pattern-write beats.
// Optional macro LED_SCAN_EN scans the capture buffer onto LED_OUT with a DIV_COUNT divider.
module burst_stream_master #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DIV_COUNT = 10000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [1:0]        mode,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_resp,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] LED_OUT
);

  localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  if (BURST_LEN < 2 || BURST_LEN > 256 || DIV_COUNT < 2) begin : g_param_check
    $error("burst_stream_master: BURST_LEN must be 2..256 and DIV_COUNT >= 2");
  end

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic              aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d, w_last_q, w_last_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [7:0]        ar_len_q, ar_len_d, aw_len_q, aw_len_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [DATA_W-1:0] buf_q [BURST_LEN];
  logic              buf_we_c, rd_final_c;
  logic [CW-1:0]     pat_k_c;
  logic [DATA_W-1:0] two_k_c, pat_c;

  // Next-beat write pattern: beat 0 on the address handshake, cnt+1 while streaming.
  always_comb begin
    pat_k_c = (state_q == WR_DATA) ? CW'(cnt_q + CW'(1)) : '0;
    two_k_c = DATA_W'({pat_k_c, 1'b0});
    pat_c   = two_k_c;
    case (mode)
      2'd0: pat_c = two_k_c;
      2'd1: pat_c = two_k_c | DATA_W'(1);
      2'd2: pat_c = ~two_k_c;
      2'd3: pat_c = buf_q[pat_k_c];
      default: pat_c = two_k_c;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    w_last_d   = w_last_q;
    ar_addr_d  = ar_addr_q;
    aw_addr_d  = aw_addr_q;
    ar_len_d   = ar_len_q;
    aw_len_d   = aw_len_q;
    w_data_d   = w_data_q;
    error_d    = error_q;
    done_d     = 1'b0;
    buf_we_c   = 1'b0;
    rd_final_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_en) begin
          state_d    = RD_ADDR;
          ar_valid_d = 1'b1;
          ar_addr_d  = ADDR_W'(BASE_ADDR);
          ar_len_d   = 8'(BURST_LEN - 1);
          error_d    = 1'b0;
        end else if (write_en) begin
          state_d    = WR_ADDR;
          aw_valid_d = 1'b1;
          aw_addr_d  = ADDR_W'(BASE_ADDR);
          aw_len_d   = 8'(BURST_LEN - 1);
          error_d    = 1'b0;
        end
      end
      RD_ADDR: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          cnt_d      = '0;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_valid && r_ready_q) begin
          buf_we_c = 1'b1;
          if (r_last != (cnt_q == LAST)) error_d = 1'b1;
          if (cnt_q == LAST) begin
            rd_final_c = 1'b1;
            r_ready_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d = CW'(cnt_q + CW'(1));
          end
        end
      end
      WR_ADDR: begin
        if (aw_ready) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b1;
          w_data_d   = pat_c;
          w_last_d   = (LAST == '0);
          cnt_d      = '0;
          state_d    = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_ready && w_valid_q) begin
          if (cnt_q == LAST) begin
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            b_ready_d = 1'b1;
            state_d   = WR_RESP;
          end else begin
            cnt_d    = pat_k_c;
            w_data_d = pat_c;
            w_last_d = (pat_k_c == LAST);
          end
        end
      end
      WR_RESP: begin
        if (b_valid && b_ready_q) begin
          b_ready_d = 1'b0;
          done_d    = 1'b1;
          if (b_resp != 2'd0) error_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      w_last_q   <= 1'b0;
      ar_addr_q  <= '0;
      aw_addr_q  <= '0;
      ar_len_q   <= '0;
      aw_len_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      for (int i = 0; i < int'(BURST_LEN); i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      w_last_q   <= w_last_d;
      ar_addr_q  <= ar_addr_d;
      aw_addr_q  <= aw_addr_d;
      ar_len_q   <= ar_len_d;
      aw_len_q   <= aw_len_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      if (buf_we_c) buf_q[cnt_q] <= r_data;
    end
  end

`ifdef LED_SCAN_EN
  localparam int unsigned DW = $clog2(DIV_COUNT);
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] idx_q, idx_d;

  // Free-running divider; each tick outside RD_DATA shows the next buffer entry.
  always_comb begin
    div_d = (div_q == DW'(DIV_COUNT - 1)) ? '0 : DW'(div_q + DW'(1));
    idx_d = idx_q;
    led_d = led_q;
    if (state_q == RD_DATA) begin
      led_d = '0;
    end else if (div_q == '0) begin
      led_d = buf_q[idx_q];
      idx_d = (idx_q == LAST) ? '0 : CW'(idx_q + CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      led_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      led_q <= led_d;
    end
  end
`else
  // Final beat of a read burst is also the displayed value.
  always_comb begin
    led_d = rd_final_c ? r_data : led_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) led_q <= '0;
    else       led_q <= led_d;
  end
`endif

  assign ar_valid = ar_valid_q;
  assign ar_addr  = ar_addr_q;
  assign ar_len   = ar_len_q;
  assign r_ready  = r_ready_q;
  assign aw_valid = aw_valid_q;
  assign aw_addr  = aw_addr_q;
  assign aw_len   = aw_len_q;
  assign w_valid  = w_valid_q;
  assign w_data   = w_data_q;
  assign w_last   = w_last_q;
  assign b_ready  = b_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign LED_OUT  = led_q;

endmodule
